lfsr_rand_gen: RTL and testbench
================================

// Module: lfsr_rand_gen
// PURPOSE
//  Parametrised Fibonacci LFSR random-number generator with seed load, free-run mode and a req/valid/ack draw handshake.
//  Each draw advances the LFSR STEPS times to decorrelate consecutive outputs.
//  Serves game logic (spawn position, produce type) that needs on-demand pseudo-random words.
// PARAMETERS
//  WIDTH       8      LFSR / output width, >= 3
//  TAPS        8'hB8  feedback mask (WIDTH bits); bit i set => state[i] XORed into feedback; 8'hB8 gives period 255
//  RESET_SEED  8'h01  state after reset, and zero-guard substitute; must be nonzero
//  STEPS       8      LFSR advances per draw, >= 1
//  CNT_W       16     width of completed-draw counter
// PORTS
//  clk         in   1       rising-edge clock
//  clr_n       in   1       reset, asynchronous, active-low
//  seed_load   in   1       load seed into LFSR this edge
//  seed        in   WIDTH   seed value
//  free_run    in   1       advance LFSR every cycle while IDLE
//  req         in   1       draw request
//  ready       out  1       draw can be accepted (IDLE)
//  valid       out  1       out holds a completed draw
//  ack         in   1       consumer has taken out
//  out         out  WIDTH   current LFSR state (qualified by valid)
//  draw_count  out  CNT_W   completed handshakes, wraps modulo 2^CNT_W
//  zero_flag   out  1       zero seed was substituted (sticky)
// BEHAVIOUR
//  - Step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
//  - Reset (clr_n=0, asynchronous): state=RESET_SEED, FSM=IDLE, valid=0, ready=1, draw_count=0, zero_flag=0.
//  - FSM IDLE: ready=1. req sampled high => RUN, step counter=0, no step on this edge. Otherwise step iff free_run.
//  - FSM RUN: ready=0, valid=0. One step per edge. After the STEPS-th step => DONE.
//      valid therefore rises exactly STEPS edges after the accepting edge.
//  - FSM DONE: valid=1, ready=0. State frozen and out stable regardless of free_run.
//      ack sampled high => IDLE, draw_count+1.
//  - Priority per edge: seed_load > FSM action.
//  - seed_load in any state: state=seed, FSM=IDLE, valid drops next cycle. An in-flight or unacked draw is discarded, and draw_count is unchanged.
//  - Ignored inputs: req while ready=0 (no queueing); ack while valid=0.
//  - req and ack together in DONE: only the ack takes effect. A new req is accepted no earlier than the following cycle.
//  - draw_count wraps from all-ones to 0.
//  - All outputs are registered or decode FSM state directly; out = state register.
// CONFIGURATION
//  - Macro LFSR_ZERO_GUARD_EN defined:
//      seed_load with seed==0 loads RESET_SEED instead and sets zero_flag.
//      zero_flag holds until reset.
//  - Macro LFSR_ZERO_GUARD_EN undefined:
//      zero seed loaded as-is; LFSR locks at 0 until the next nonzero seed or reset.
//      zero_flag tied 0.
// STRUCTURE
//  - Package lfsr_pkg:
//      FSM state encoding IDLE/RUN/DONE (2-bit);
//      default TAPS constants for widths 8, 16, 32 (8'hB8, 16'hB400, 32'h80200003).
//  - Sub-module lfsr_step: combinational WIDTH/TAPS next-state function.
//      Instanced once; reused by the bench as a reference model.
//  - Top holds the state register, FSM, step counter ($clog2(STEPS+1) bits), draw counter and zero-guard logic.
// TESTING
//  1. Reset; seed_load 0x01; free_run=1 for 255 cycles
//     -> sequence starts 0x01,0x02,0x04,0x08,0x11; state returns to 0x01 at cycle 255, no earlier repeat.
//  2. STEPS=4, seed 0x01, req one cycle
//     -> ready low next cycle; valid high 4 edges after accept with out=0x11;
//     -> hold ack=0 for 3 cycles: out stays 0x11;
//     -> ack: valid=0, ready=1, draw_count=1.
//  3. req, then seed_load 0x5A on the 2nd RUN cycle
//     -> valid never asserts; out=0x5A; ready=1 next cycle; draw_count unchanged.
//  4. seed_load 0x00
//     -> with LFSR_ZERO_GUARD_EN: out=0x01, zero_flag=1;
//     -> without: out=0x00 and stays 0 under free_run, zero_flag=0.
//  5. Assert clr_n=0 asynchronously while in DONE
//     -> valid=0 and out=RESET_SEED immediately, before the next clock edge; draw_count=0.
//  6. CNT_W=2, four complete draws -> draw_count 1,2,3,0; req+ack together in DONE -> no new draw starts that cycle.

Source files
------------

// File: rtl/lfsr_rand_gen_pkg.sv
// Shared types and constants for the LFSR random-number generator.
// Holds the draw FSM encoding and default Fibonacci feedback masks
// for common widths.
package lfsr_pkg;

    // Draw FSM: IDLE accepts requests, RUN advances the LFSR, DONE presents a word
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lfsr_state_e;

    // Maximal-length feedback masks (bit i set => state[i] feeds the XOR)
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Draw handshake bundle for lfsr_rand_gen.
// The consumer (master) raises req and ack; the generator (slave)
// reports ready/valid and presents the random word on out.
interface lfsr_rand_gen_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             ready;
    logic             valid;
    logic             ack;
    logic [WIDTH-1:0] out;

    modport master (
        output req,
        output ack,
        input  ready,
        input  valid,
        input  out
    );

    modport slave (
        input  req,
        input  ack,
        output ready,
        output valid,
        output out
    );
endinterface

// File: rtl/lfsr_rand_gen_step.sv
// Combinational next-state function of a Fibonacci LFSR.
// Shifts left by one and inserts the parity of the tapped bits at bit 0.
module lfsr_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    // Feedback bit is the XOR of every tapped state bit
    assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};

endmodule

// File: rtl/lfsr_rand_gen.sv
// On-demand pseudo-random word generator built on a Fibonacci LFSR.
// A draw accepted in IDLE advances the LFSR STEPS times before the word
// is presented with valid; the consumer retires it with ack.
// Optional feature: define LFSR_ZERO_GUARD_EN to replace a zero seed with
// RESET_SEED and record the event on the sticky zero_flag.
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = TAPS_W8,
    parameter logic [WIDTH-1:0] RESET_SEED = 8'h01,
    parameter int               STEPS      = 8,
    parameter int               CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    input  logic                 free_run,
    lfsr_rand_gen_if.slave       bus,
    output logic [CNT_W-1:0]     draw_count,
    output logic                 zero_flag
);

    localparam int               STEP_W    = $clog2(STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    lfsr_state_e       fsm_q;
    logic [WIDTH-1:0]  lfsr_q;
    logic [WIDTH-1:0]  lfsr_next;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step_cnt_q;
    logic [CNT_W-1:0]  draw_count_q;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state      (lfsr_q),
        .next_state (lfsr_next)
    );

`ifdef LFSR_ZERO_GUARD_EN
    logic zero_flag_q;

    // An all-zero seed would lock the LFSR, so substitute the reset seed
    assign load_val = (seed == '0) ? RESET_SEED : seed;

    // Sticky record that a zero seed was rejected; only reset clears it
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            zero_flag_q <= 1'b0;
        end else if (seed_load && (seed == '0)) begin
            zero_flag_q <= 1'b1;
        end
    end

    assign zero_flag = zero_flag_q;
`else
    // Seed is loaded as given; a zero seed parks the LFSR at zero
    assign load_val  = seed;
    assign zero_flag = 1'b0;
`endif

    // LFSR state, draw FSM, step counter and completed-draw counter;
    // seed_load overrides any FSM action and abandons an open draw
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lfsr_q       <= RESET_SEED;
            fsm_q        <= ST_IDLE;
            step_cnt_q   <= '0;
            draw_count_q <= '0;
        end else if (seed_load) begin
            lfsr_q     <= load_val;
            fsm_q      <= ST_IDLE;
            step_cnt_q <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (bus.req) begin
                        fsm_q      <= ST_RUN;
                        step_cnt_q <= '0;
                    end else if (free_run) begin
                        lfsr_q <= lfsr_next;
                    end
                end
                ST_RUN: begin
                    lfsr_q <= lfsr_next;
                    if (step_cnt_q == LAST_STEP) begin
                        fsm_q <= ST_DONE;
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    // Word is frozen until retired; a simultaneous req is ignored
                    if (bus.ack) begin
                        fsm_q        <= ST_IDLE;
                        draw_count_q <= draw_count_q + CNT_W'(1);
                    end
                end
                default: begin
                    fsm_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = (fsm_q == ST_IDLE);
    assign bus.valid  = (fsm_q == ST_DONE);
    assign bus.out    = lfsr_q;
    assign draw_count = draw_count_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench for lfsr_rand_gen (WIDTH=8, STEPS=4, CNT_W=2).
// A behavioural model tracks the expected outputs every cycle; directed
// scenarios add literal expectations, followed by randomized traffic.
module tb_lfsr_rand_gen;

    localparam int         WIDTH = 8;
    localparam int         STEPS = 4;
    localparam int         CNT_W = 2;
    localparam logic [7:0] TAPS  = 8'hB8;
    localparam logic [7:0] RSEED = 8'h01;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             seed_load = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic             free_run = 1'b0;
    logic [CNT_W-1:0] draw_count;
    logic             zero_flag;

    int checks = 0;
    int errors = 0;

    lfsr_rand_gen_if #(.WIDTH(WIDTH)) bus ();

    lfsr_rand_gen #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_SEED (RSEED),
        .STEPS      (STEPS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .seed_load  (seed_load),
        .seed       (seed),
        .free_run   (free_run),
        .bus        (bus),
        .draw_count (draw_count),
        .zero_flag  (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for a request, 1 drawing, 2 word presented
    logic [7:0] m_state = RSEED;
    int         m_mode  = 0;
    int         m_left  = 0;
    int         m_count = 0;
    bit         m_zf    = 1'b0;
    bit         guard;

    initial begin
`ifdef LFSR_ZERO_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
    end

    function automatic logic [7:0] m_next(input logic [7:0] s);
        int p;
        p = $countones(s & TAPS) % 2;
        return 8'((int'(s) * 2 + p) % 256);
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_state = RSEED;
            m_mode  = 0;
            m_left  = 0;
            m_count = 0;
            m_zf    = 1'b0;
        end else if (seed_load) begin
            if (guard && seed == 8'h00) begin
                m_state = RSEED;
                m_zf    = 1'b1;
            end else begin
                m_state = seed;
            end
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (bus.req) begin
                m_mode = 1;
                m_left = STEPS;
            end else if (free_run) begin
                m_state = m_next(m_state);
            end
        end else if (m_mode == 1) begin
            m_state = m_next(m_state);
            m_left--;
            if (m_left == 0) m_mode = 2;
        end else begin
            if (bus.ack) begin
                m_mode  = 0;
                m_count = (m_count + 1) % (1 << CNT_W);
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk) begin
        #1;
        check("cyc_ready", bus.ready, (m_mode == 0));
        check("cyc_valid", bus.valid, (m_mode == 2));
        check("cyc_out", bus.out, m_state);
        check("cyc_draw_count", draw_count, m_count);
        check("cyc_zero_flag", zero_flag, m_zf);
    end

    // Run one draw to DONE within a bounded number of cycles
    task automatic start_draw_wait_valid(input string name);
        bit got;
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) got = 1'b1;
        end
        check(name, got, 1'b1);
    endtask

    initial begin
        bit         seen [256];
        logic [7:0] vals [256];
        int         ndist;
        int         first_rep;
        bit         saw_valid;

        bus.req = 1'b0;
        bus.ack = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready, 1'b1);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_out", bus.out, 8'h01);
        check("rst_count", draw_count, 0);
        check("rst_zero_flag", zero_flag, 1'b0);
        clr_n = 1'b1;

        // ---------------- free-run period ----------------
        seed_load = 1'b1; seed = 8'h01; free_run = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("fr_load", bus.out, 8'h01);
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            vals[k] = bus.out;
        end
        free_run = 1'b0;
        check("fr_s1", vals[1], 8'h02);
        check("fr_s2", vals[2], 8'h04);
        check("fr_s3", vals[3], 8'h08);
        check("fr_s4", vals[4], 8'h11);
        check("fr_s255", vals[255], 8'h01);
        ndist = 0;
        first_rep = 0;
        for (int k = 1; k <= 255; k++) begin
            if (!seen[vals[k]]) ndist++;
            seen[vals[k]] = 1'b1;
            if (vals[k] == 8'h01 && first_rep == 0) first_rep = k;
        end
        check("fr_distinct", ndist, 255);
        check("fr_first_repeat", first_rep, 255);

        // ---------------- single draw ----------------
        seed_load = 1'b1; seed = 8'h01;
        @(negedge clk);
        seed_load = 1'b0;
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        check("d_ready_low", bus.ready, 1'b0);
        check("d_valid_low0", bus.valid, 1'b0);
        repeat (3) @(negedge clk);
        check("d_valid_low3", bus.valid, 1'b0);
        @(negedge clk);
        check("d_valid_4", bus.valid, 1'b1);
        check("d_out", bus.out, 8'h11);
        free_run = 1'b1;
        repeat (3) @(negedge clk);
        check("d_hold_out", bus.out, 8'h11);
        check("d_hold_valid", bus.valid, 1'b1);
        free_run = 1'b0;
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check("d_ack_valid", bus.valid, 1'b0);
        check("d_ack_ready", bus.ready, 1'b1);
        check("d_ack_count", draw_count, 1);

        // ---------------- abort by seed_load ----------------
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        seed_load = 1'b1; seed = 8'h5A;
        @(negedge clk);
        seed_load = 1'b0;
        check("ab_out", bus.out, 8'h5A);
        check("ab_ready", bus.ready, 1'b1);
        check("ab_count", draw_count, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.valid !== 1'b0) saw_valid = 1'b1;
        end
        check("ab_no_valid", saw_valid, 1'b0);

        // ---------------- zero seed ----------------
        seed_load = 1'b1; seed = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
        check("z_out", bus.out, 8'h01);
        check("z_flag", zero_flag, 1'b1);
`else
        check("z_out", bus.out, 8'h00);
        check("z_flag", zero_flag, 1'b0);
        free_run = 1'b1;
        repeat (5) @(negedge clk);
        free_run = 1'b0;
        check("z_locked", bus.out, 8'h00);
`endif
        seed_load = 1'b1; seed = 8'h01;
        @(negedge clk);
        seed_load = 1'b0;

        // ---------------- async reset in DONE ----------------
        start_draw_wait_valid("ar_reach_done");
        #2;
        clr_n = 1'b0;
        #1;
        check("ar_valid", bus.valid, 1'b0);
        check("ar_out", bus.out, 8'h01);
        check("ar_count", draw_count, 0);
        check("ar_ready", bus.ready, 1'b1);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // ---------------- counter wrap ----------------
        for (int i = 1; i <= 4; i++) begin
            start_draw_wait_valid("cw_valid");
            bus.ack = 1'b1;
            @(negedge clk);
            bus.ack = 1'b0;
            check("cw_count", draw_count, i % 4);
        end

        // ---------------- req with ack in DONE ----------------
        start_draw_wait_valid("ra_reach_done");
        bus.req = 1'b1;
        bus.ack = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        bus.ack = 1'b0;
        check("ra_ready", bus.ready, 1'b1);
        check("ra_valid", bus.valid, 1'b0);
        check("ra_count", draw_count, 1);
        @(negedge clk);
        check("ra_no_draw", bus.ready, 1'b1);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 800; i++) begin
            seed_load = ($urandom_range(0, 19) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bus.req   = ($urandom_range(0, 2) == 0);
            bus.ack   = ($urandom_range(0, 2) == 0);
            free_run  = ($urandom_range(0, 1) == 0);
            @(negedge clk);
        end
        seed_load = 1'b0;
        bus.req   = 1'b0;
        bus.ack   = 1'b0;
        free_run  = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
